sent_tx_frame_ctrl: RTL and testbench

SENT (SAE J2716) transmit frame sequencer. It sits directly upstream of the tick-level pulse generator. It accepts a frame (status nibble plus data nibbles) through a valid/ready handshake and buffers it in a one-entry holding register. It computes the CRC4, then drives the pulse generator symbol by symbol (sync, status, data, CRC, optional pause), advancing on each pulse-done strobe.

---
 rtl/sent_pkg.sv | 24 ++
 rtl/sent_tx_frame_ctrl_if.sv | 12 +
 rtl/sent_tx_crc4.sv | 25 ++
 rtl/sent_tx_frame_ctrl.sv | 156 +++++++++++++++
 tb/tb_sent_tx_frame_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sent_pkg.sv
// Shared types and constants for the SENT transmit frame sequencer.
// The CRC table and step helper are used by sent_tx_crc4.
package sent_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_STATUS,
        ST_DATA,
        ST_CRC,
        ST_PAUSE
    } state_t;

    localparam logic [3:0] SENT_CRC_SEED    = 4'b0101;
    localparam int         MAX_DATA_NIBBLES = 6;

    // Entry i sits at bits [4*i+3:4*i]; entry 0 is the least significant nibble.
    localparam logic [63:0] SENT_CRC4_TABLE = 64'h582F_B6C1_493E_A7D0;

    function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic [3:0] nibble);
        return SENT_CRC4_TABLE[{c, 2'b00} +: 4] ^ nibble;
    endfunction

endpackage

// File: rtl/sent_tx_frame_ctrl_if.sv
// Upstream frame handshake into the SENT frame sequencer.
// A frame transfers on every clock edge where frame_valid_i and frame_ready_o are both high;
// valid offered while ready is low is simply not taken, and the source may change or drop it.
interface sent_tx_frame_ctrl_if;
    logic        frame_valid_i;
    logic        frame_ready_o;
    logic [3:0]  status_i;
    logic [23:0] frame_data_i;

    modport master (output frame_valid_i, output status_i, output frame_data_i, input frame_ready_o);
    modport slave  (input frame_valid_i, input status_i, input frame_data_i, output frame_ready_o);
endinterface

// File: rtl/sent_tx_crc4.sv
// Combinational SENT CRC4 over the leading NUM_DATA_NIBBLES nibbles, with the final
// zero-nibble augmentation step applied.
module sent_tx_crc4
    import sent_pkg::*;
#(
    parameter int NUM_DATA_NIBBLES = 6
) (
    input  logic [23:0] data,
    output logic [3:0]  crc
);

    logic [3:0] c;

    always_comb begin
        c = SENT_CRC_SEED;
        for (int i = 0; i < MAX_DATA_NIBBLES; i++) begin
            if (i < NUM_DATA_NIBBLES) begin
                c = crc4_step(c, data[23 - 4*i -: 4]);
            end
        end
        c   = crc4_step(c, 4'h0);
        crc = c;
    end

endmodule

// File: rtl/sent_tx_frame_ctrl.sv
// SENT transmit frame sequencer: one-entry frame buffer feeding a symbol FSM that drives the
// pulse generator. Build macro SENT_PAUSE_EN adds a pause symbol after the CRC.
module sent_tx_frame_ctrl
    import sent_pkg::*;
#(
    parameter int NUM_DATA_NIBBLES = 6
) (
    input  logic                 ticks_i,
    input  logic                 reset_n_tx,
    sent_tx_frame_ctrl_if.slave  frame,
    input  logic                 pulse_done_i,
    output logic                 sync_o,
    output logic                 pulse_o,
    output logic [3:0]           data_nibble_o,
    output logic                 pause_o,
    output logic                 idle_o,
    output logic                 frame_done_o,
    output logic                 busy_o,
    output state_t               state_dbg
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_DATA_NIBBLES - 1);

    state_t      state_q, state_nx;
    logic [2:0]  idx_q, idx_nx;
    logic        buf_full;
    logic [3:0]  buf_status, wk_status;
    logic [23:0] buf_data, wk_data;
    logic [3:0]  crc_buf, crc_q;
    logic        pop, last_done;
    logic [3:0]  nibble_nx;

    assign frame.frame_ready_o = ~buf_full;
    assign state_dbg           = state_q;

    sent_tx_crc4 #(.NUM_DATA_NIBBLES(NUM_DATA_NIBBLES)) u_crc (
        .data (buf_data),
        .crc  (crc_buf)
    );

    always_ff @(posedge ticks_i or negedge reset_n_tx) begin
        if (!reset_n_tx) state_q <= ST_IDLE;
        else             state_q <= state_nx;
    end

    always_comb begin
        state_nx  = state_q;
        idx_nx    = idx_q;
        pop       = 1'b0;
        last_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (buf_full) begin
                    pop      = 1'b1;
                    state_nx = ST_SYNC;
                end
            end
            ST_SYNC:   if (pulse_done_i) state_nx = ST_STATUS;
            ST_STATUS: begin
                if (pulse_done_i) begin
                    state_nx = ST_DATA;
                    idx_nx   = 3'd0;
                end
            end
            ST_DATA: begin
                if (pulse_done_i) begin
                    if (idx_q == LAST_IDX) state_nx = ST_CRC;
                    else                   idx_nx   = idx_q + 3'd1;
                end
            end
`ifdef SENT_PAUSE_EN
            ST_CRC:   if (pulse_done_i) state_nx = ST_PAUSE;
            ST_PAUSE: if (pulse_done_i) last_done = 1'b1;
`else
            ST_CRC:   if (pulse_done_i) last_done = 1'b1;
`endif
            default: state_nx = ST_IDLE;
        endcase
        // Back-to-back frames go straight to SYNC with no idle symbol in between.
        if (last_done) begin
            idx_nx = 3'd0;
            if (buf_full) begin
                pop      = 1'b1;
                state_nx = ST_SYNC;
            end else begin
                state_nx = ST_IDLE;
            end
        end
    end

    always_comb begin
        nibble_nx = 4'h0;
        case (state_nx)
            ST_STATUS: nibble_nx = wk_status;
            ST_DATA: begin
                case (idx_nx)
                    3'd0:    nibble_nx = wk_data[23:20];
                    3'd1:    nibble_nx = wk_data[19:16];
                    3'd2:    nibble_nx = wk_data[15:12];
                    3'd3:    nibble_nx = wk_data[11:8];
                    3'd4:    nibble_nx = wk_data[7:4];
                    3'd5:    nibble_nx = wk_data[3:0];
                    default: nibble_nx = 4'h0;
                endcase
            end
            ST_CRC:  nibble_nx = crc_q;
            default: nibble_nx = 4'h0;
        endcase
    end

    always_ff @(posedge ticks_i or negedge reset_n_tx) begin
        if (!reset_n_tx) begin
            idx_q         <= 3'd0;
            buf_full      <= 1'b0;
            buf_status    <= 4'h0;
            buf_data      <= 24'h0;
            wk_status     <= 4'h0;
            wk_data       <= 24'h0;
            crc_q         <= 4'h0;
            sync_o        <= 1'b0;
            pulse_o       <= 1'b0;
            data_nibble_o <= 4'h0;
            idle_o        <= 1'b1;
            frame_done_o  <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            idx_q <= idx_nx;
            if (pop) begin
                wk_status <= buf_status;
                wk_data   <= buf_data;
                crc_q     <= crc_buf;
                buf_full  <= 1'b0;
            end else if (frame.frame_valid_i && !buf_full) begin
                buf_status <= frame.status_i;
                buf_data   <= frame.frame_data_i;
                buf_full   <= 1'b1;
            end
            sync_o        <= (state_nx == ST_SYNC);
            pulse_o       <= (state_nx == ST_STATUS) || (state_nx == ST_DATA) || (state_nx == ST_CRC);
            data_nibble_o <= nibble_nx;
            idle_o        <= (state_nx == ST_IDLE);
            frame_done_o  <= last_done;
            busy_o        <= (state_nx != ST_IDLE);
        end
    end

`ifdef SENT_PAUSE_EN
    always_ff @(posedge ticks_i or negedge reset_n_tx) begin
        if (!reset_n_tx) pause_o <= 1'b0;
        else             pause_o <= (state_nx == ST_PAUSE);
    end
`else
    assign pause_o = 1'b0;
`endif

endmodule

// File: tb/tb_sent_tx_frame_ctrl.sv
// Bench for sent_tx_frame_ctrl: a six-nibble and a one-nibble instance, a pulse generator
// model, and a symbol scoreboard fed at frame acceptance.
module tb_sent_tx_frame_ctrl;
  import sent_pkg::*;

  localparam int P = 6;
`ifdef SENT_PAUSE_EN
  localparam logic [1:0] LAST_KIND = 2'd2;
`else
  localparam logic [1:0] LAST_KIND = 2'd1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        valid [2] = '{1'b0, 1'b0};
  logic [3:0]  status [2] = '{4'h0, 4'h0};
  logic [23:0] data [2] = '{24'h0, 24'h0};
  logic        pd [2] = '{1'b0, 1'b0};
  logic        ready [2];
  logic        sync [2], pulse [2], pause [2], idle [2], fdone [2], busy [2];
  logic [3:0]  nib [2];
  state_t      st [2];

  sent_tx_frame_ctrl_if bus0 ();
  sent_tx_frame_ctrl_if bus1 ();
  assign bus0.frame_valid_i = valid[0];
  assign bus0.status_i      = status[0];
  assign bus0.frame_data_i  = data[0];
  assign ready[0]           = bus0.frame_ready_o;
  assign bus1.frame_valid_i = valid[1];
  assign bus1.status_i      = status[1];
  assign bus1.frame_data_i  = data[1];
  assign ready[1]           = bus1.frame_ready_o;

  sent_tx_frame_ctrl #(.NUM_DATA_NIBBLES(6)) dut0 (
    .ticks_i(clk), .reset_n_tx(rst_n), .frame(bus0.slave), .pulse_done_i(pd[0]),
    .sync_o(sync[0]), .pulse_o(pulse[0]), .data_nibble_o(nib[0]), .pause_o(pause[0]),
    .idle_o(idle[0]), .frame_done_o(fdone[0]), .busy_o(busy[0]), .state_dbg(st[0])
  );

  sent_tx_frame_ctrl #(.NUM_DATA_NIBBLES(1)) dut1 (
    .ticks_i(clk), .reset_n_tx(rst_n), .frame(bus1.slave), .pulse_done_i(pd[1]),
    .sync_o(sync[1]), .pulse_o(pulse[1]), .data_nibble_o(nib[1]), .pause_o(pause[1]),
    .idle_o(idle[1]), .frame_done_o(fdone[1]), .busy_o(busy[1]), .state_dbg(st[1])
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [6:0] exp_q[$];
  int acc_cnt [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int cnt [2] = '{0, 0};
  logic prev_fd [2] = '{1'b0, 1'b0};
  logic [1:0] last_kind [2] = '{2'd0, 2'd0};
  bit mon_en = 1'b0;
  logic [3:0] tbl [16] = '{4'd0, 4'd13, 4'd7, 4'd10, 4'd14, 4'd3, 4'd9, 4'd4,
                           4'd1, 4'd12, 4'd6, 4'd11, 4'd15, 4'd2, 4'd8, 4'd5};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_crc(input logic [23:0] d, input int n);
    logic [3:0] c;
    logic [23:0] t;
    c = 4'd5;
    t = d;
    for (int i = 0; i < n; i++) begin
      c = tbl[c] ^ t[23:20];
      t = t << 4;
    end
    return tbl[c];
  endfunction

  // Symbol code: {instance, kind(0 sync,1 pulse,2 pause), nibble}
  task automatic push_frame(input int k, input logic [3:0] s, input logic [23:0] d);
    int n;
    logic [23:0] t;
    logic kb;
    n = (k == 0) ? 6 : 1;
    kb = (k != 0);
    t = d;
    exp_q.push_back({kb, 2'd0, 4'h0});
    exp_q.push_back({kb, 2'd1, s});
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({kb, 2'd1, t[23:20]});
      t = t << 4;
    end
    exp_q.push_back({kb, 2'd1, ref_crc(d, n)});
`ifdef SENT_PAUSE_EN
    exp_q.push_back({kb, 2'd2, 4'h0});
`endif
  endtask

  task automatic send_frame(input int k, input logic [3:0] s, input logic [23:0] d);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    valid[k] = 1'b1;
    status[k] = s;
    data[k] = d;
    for (int t = 0; t < 3000 && !ok; t++) begin
      if (ready[k]) begin
        push_frame(k, s, d);
        @(posedge clk);
        acc_cnt[k]++;
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    valid[k] = 1'b0;
    if (ok) check("ready_after_accept", 32'(ready[k]), 32'd0);
  endtask

  task automatic wait_idle(input int k);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 5000 && !ok; t++) begin
      @(negedge clk);
      if (done_cnt[k] == acc_cnt[k] && idle[k] && ready[k]) ok = 1'b1;
    end
    check("idle_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_state(input int k, input state_t s);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk);
      if (st[k] == s) ok = 1'b1;
    end
    check("state_timeout", 32'(ok), 32'd1);
  endtask

  task automatic check_reset_outputs(input int k);
    check("rst_idle", 32'(idle[k]), 32'd1);
    check("rst_ready", 32'(ready[k]), 32'd1);
    check("rst_sync", 32'(sync[k]), 32'd0);
    check("rst_pulse", 32'(pulse[k]), 32'd0);
    check("rst_pause", 32'(pause[k]), 32'd0);
    check("rst_nibble", 32'(nib[k]), 32'd0);
    check("rst_frame_done", 32'(fdone[k]), 32'd0);
    check("rst_busy", 32'(busy[k]), 32'd0);
  endtask

  // Pulse generator model and output monitor.
  initial begin
    logic [1:0] kind;
    logic [3:0] nv;
    logic [6:0] sym;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!mon_en) begin
          pd[k] = 1'b0;
          cnt[k] = 0;
          prev_fd[k] = 1'b0;
        end else begin
          check("one_hot", 32'(sync[k]) + 32'(pulse[k]) + 32'(pause[k]) + 32'(idle[k]), 32'd1);
          check("busy_vs_idle", 32'(busy[k]), 32'(!idle[k]));
          if (fdone[k]) begin
            done_cnt[k]++;
            check("frame_done_width", 32'(prev_fd[k]), 32'd0);
            check("frame_done_last_kind", 32'(last_kind[k]), 32'(LAST_KIND));
            check("back_to_back_sync", 32'(sync[k]), 32'(acc_cnt[k] > done_cnt[k]));
          end
          prev_fd[k] = fdone[k];
          pd[k] = 1'b0;
          if (idle[k]) begin
            cnt[k] = 0;
          end else if (cnt[k] == P - 1) begin
            kind = sync[k] ? 2'd0 : pulse[k] ? 2'd1 : pause[k] ? 2'd2 : 2'd3;
            nv = pulse[k] ? nib[k] : 4'h0;
            sym = {(k != 0), kind, nv};
            if (exp_q.size() == 0) check("symbol_unexpected", 32'(sym), 32'h80);
            else check("symbol", 32'(sym), 32'(exp_q.pop_front()));
            last_kind[k] = kind;
            pd[k] = 1'b1;
            cnt[k] = 0;
          end else begin
            cnt[k]++;
          end
        end
      end
    end
  end

  initial begin
    #23;
    check_reset_outputs(0);
    check_reset_outputs(1);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    send_frame(0, 4'h0, 24'h000000);
    wait_idle(0);
    send_frame(0, 4'hA, 24'h123456);
    wait_idle(0);

    send_frame(0, 4'h3, 24'hABCDEF);
    wait_state(0, ST_DATA);
    send_frame(0, 4'h5, 24'h0F1E2D);
    @(negedge clk);
    valid[0] = 1'b1;
    status[0] = 4'hC;
    data[0] = 24'h987654;
    check("held_off_while_full", 32'(ready[0]), 32'd0);
    send_frame(0, 4'hC, 24'h987654);
    wait_idle(0);

    for (int i = 0; i < 3; i++) begin
      send_frame(0, 4'($urandom_range(0, 15)), 24'($urandom_range(0, 32'hFFFFFF)));
      wait_idle(0);
    end

    send_frame(1, 4'h7, 24'h300000);
    wait_idle(1);

    send_frame(0, 4'h9, 24'h55AA33);
    wait_state(0, ST_DATA);
    @(negedge clk);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(0);
    check("rst_state", 32'(st[0]), 32'(ST_IDLE));
    exp_q.delete();
    acc_cnt[0] = done_cnt[0];
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    send_frame(0, 4'h1, 24'h2468AC);
    wait_idle(0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("frames_done_inst0", 32'(done_cnt[0]), 32'(acc_cnt[0]));
    check("frames_done_inst1", 32'(done_cnt[1]), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
